// File: rtl/dmem_responder_pkg.sv
// Shared bus encodings, tag width and the pending-load entry layout for the
// data-memory responder.
package dmem_responder_pkg;

  localparam int XLEN         = 32;
  localparam int MEM_TAG_BITS = 4;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } bus_command_e;

  typedef struct packed {
    logic        busy;
    logic [3:0]  countdown;
    logic [63:0] data;
  } MEM_PEND_ENTRY;

endpackage

// File: rtl/dmem_tag_table.sv
// Pending-load tag table: lowest-free tag search, per-tag countdown and the
// tag/data pair that must be registered onto the return bus this cycle.
module dmem_tag_table
  import dmem_responder_pkg::*;
#(
  parameter int MEM_LATENCY = 4,
  parameter int NUM_TAGS    = 15
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    alloc_en,
  input  logic [MEM_TAG_BITS-1:0] alloc_tag,
  input  logic [63:0]             alloc_data,
  output logic [MEM_TAG_BITS-1:0] free_tag,
  output logic [MEM_TAG_BITS-1:0] exp_tag,
  output logic [63:0]             exp_data,
  output logic                    release_en
);

  MEM_PEND_ENTRY entry_q [1:NUM_TAGS];
  MEM_PEND_ENTRY entry_d [1:NUM_TAGS];
  logic [4:0]    exp_hits;

  always_comb begin
    free_tag   = '0;
    exp_tag    = '0;
    exp_data   = '0;
    release_en = 1'b0;
    exp_hits   = '0;
    for (int t = NUM_TAGS; t >= 1; t--) begin
      if (!entry_q[t].busy) free_tag = MEM_TAG_BITS'(t);
    end
    // The return register is loaded one cycle before the tag's final cycle;
    // with a latency of one that is the acceptance cycle itself.
    if (MEM_LATENCY == 1) begin
      if (alloc_en) begin
        exp_tag  = alloc_tag;
        exp_data = alloc_data;
        exp_hits = 5'd1;
      end
    end else begin
      for (int t = 1; t <= NUM_TAGS; t++) begin
        if (entry_q[t].busy && entry_q[t].countdown == 4'd2) begin
          exp_tag  = MEM_TAG_BITS'(t);
          exp_data = entry_q[t].data;
          exp_hits = exp_hits + 5'd1;
        end
      end
    end
    for (int t = 1; t <= NUM_TAGS; t++) begin
      entry_d[t] = entry_q[t];
      if (entry_q[t].busy) begin
        entry_d[t].countdown = entry_q[t].countdown - 4'd1;
        if (entry_q[t].countdown == 4'd1) begin
          entry_d[t].busy = 1'b0;
          release_en      = 1'b1;
        end
      end
      if (alloc_en && alloc_tag == MEM_TAG_BITS'(t)) begin
        entry_d[t].busy      = 1'b1;
        entry_d[t].countdown = 4'(MEM_LATENCY);
        entry_d[t].data      = alloc_data;
      end
    end
  end

  always_ff @(posedge clock) begin
    for (int t = 1; t <= NUM_TAGS; t++) begin
      if (reset) begin
        entry_q[t].busy      <= 1'b0;
        entry_q[t].countdown <= 4'd0;
      end else begin
        entry_q[t] <= entry_d[t];
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (exp_hits <= 5'd1)
        else $error("dmem_tag_table: %0d entries expire in one cycle", exp_hits);
    end
  end
`endif

endmodule

// File: rtl/dmem_responder.sv
// Memory-side end of the proc2Dmem/Dmem2proc bus: word array, range check,
// same-cycle tag response and registered fixed-latency load returns.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int MEM_LATENCY = 4,
  parameter int MEM_WORDS   = 8192,
  parameter int NUM_TAGS    = 15
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [1:0]              proc2Dmem_command,
  input  logic [XLEN-1:0]         proc2Dmem_addr,
  input  logic [63:0]             proc2Dmem_data,
  output logic [MEM_TAG_BITS-1:0] Dmem2proc_response,
  output logic [63:0]             Dmem2proc_data,
  output logic [MEM_TAG_BITS-1:0] Dmem2proc_tag,
  output logic [4:0]              outstanding_count
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam logic [XLEN:0] BYTE_CAP = (XLEN+1)'(longint'(MEM_WORDS) * 8);

  logic [63:0]             mem_q [MEM_WORDS];
  logic [IDX_W-1:0]        idx;
  logic                    in_range, load_acc, store_acc, release_en;
  logic [MEM_TAG_BITS-1:0] free_tag, exp_tag;
  logic [63:0]             exp_data;
  logic [MEM_TAG_BITS-1:0] ret_tag_d, ret_tag_q;
  logic [63:0]             ret_data_d, ret_data_q;
  logic [4:0]              count_d, count_q;

  assign idx      = proc2Dmem_addr[3 +: IDX_W];
  assign in_range = {1'b0, proc2Dmem_addr} < BYTE_CAP;

  always_comb begin
    load_acc           = 1'b0;
    store_acc          = 1'b0;
    Dmem2proc_response = '0;
    if (in_range && proc2Dmem_command == BUS_LOAD && free_tag != '0) begin
      load_acc           = 1'b1;
      Dmem2proc_response = free_tag;
    end else if (in_range && proc2Dmem_command == BUS_STORE) begin
      // Stores never hold a tag, so they are acknowledged even when full.
      store_acc          = 1'b1;
      Dmem2proc_response = (free_tag != '0) ? free_tag : MEM_TAG_BITS'(1);
    end
  end

  dmem_tag_table #(
    .MEM_LATENCY (MEM_LATENCY),
    .NUM_TAGS    (NUM_TAGS)
  ) u_tag_table (
    .clock      (clock),
    .reset      (reset),
    .alloc_en   (load_acc),
    .alloc_tag  (free_tag),
    .alloc_data (mem_q[idx]),
    .free_tag   (free_tag),
    .exp_tag    (exp_tag),
    .exp_data   (exp_data),
    .release_en (release_en)
  );

  always_comb begin
    ret_tag_d  = exp_tag;
    ret_data_d = exp_data;
    count_d    = count_q + {4'd0, load_acc} - {4'd0, release_en};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ret_tag_q  <= '0;
      ret_data_q <= '0;
      count_q    <= '0;
    end else begin
      ret_tag_q  <= ret_tag_d;
      ret_data_q <= ret_data_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int w = 0; w < MEM_WORDS; w++) mem_q[w] <= '0;
    end else if (store_acc) begin
      mem_q[idx] <= proc2Dmem_data;
    end
  end

  assign Dmem2proc_tag     = ret_tag_q;
  assign Dmem2proc_data    = ret_data_q;
  assign outstanding_count = count_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed loads/stores push expected
// returns; a negedge monitor pops and compares whatever the DUT returns.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  cmd = 2'd0;
  logic [31:0] addr = '0;
  logic [63:0] wdata = '0;
  logic [3:0]  resp, rtag;
  logic [63:0] rdata;
  logic [4:0]  cnt;

  logic [1:0]  cmd15 = 2'd0;
  logic [31:0] addr15 = '0;
  logic [63:0] wdata15 = '0;
  logic [3:0]  resp15, rtag15;
  logic [63:0] rdata15;
  logic [4:0]  cnt15;

  int          tests = 0;
  int          fails = 0;
  int unsigned cyc = 0;
  bit          mon_en = 1'b0;

  typedef struct {
    int unsigned cyc;
    logic [3:0]  tag;
    logic [63:0] data;
  } exp_t;
  exp_t q[$];
  exp_t me;

  localparam logic [63:0] VA = 64'h1111_2222_3333_4444;
  localparam logic [63:0] VD = 64'hDEAD_BEEF_0000_0001;
  localparam logic [63:0] VA2 = 64'hAAAA_0000_0000_00A2;
  localparam logic [63:0] VB2 = 64'hBBBB_0000_0000_00B2;
  localparam logic [63:0] VC = 64'hC0C0_C0C0_1234_5678;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  dmem_responder dut (
    .clock (clock), .reset (reset),
    .proc2Dmem_command (cmd), .proc2Dmem_addr (addr), .proc2Dmem_data (wdata),
    .Dmem2proc_response (resp), .Dmem2proc_data (rdata), .Dmem2proc_tag (rtag),
    .outstanding_count (cnt)
  );

  dmem_responder #(.MEM_LATENCY(15)) dut15 (
    .clock (clock), .reset (reset),
    .proc2Dmem_command (cmd15), .proc2Dmem_addr (addr15), .proc2Dmem_data (wdata15),
    .Dmem2proc_response (resp15), .Dmem2proc_data (rdata15), .Dmem2proc_tag (rtag15),
    .outstanding_count (cnt15)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic issue(input string name, input logic [1:0] c, input logic [31:0] a,
                       input logic [63:0] d, input logic [3:0] exp_resp,
                       input logic [63:0] exp_ret);
    cmd = c; addr = a; wdata = d;
    @(negedge clock);
    chk(name, {60'd0, resp}, {60'd0, exp_resp});
    if (c == BUS_LOAD && exp_resp != 4'd0) q.push_back('{cyc + 4, exp_resp, exp_ret});
    @(posedge clock); #1;
    cmd = BUS_NONE;
  endtask

  task automatic idle(input int n);
    cmd = BUS_NONE;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic idle_cnt(input string name, input logic [4:0] exp_cnt);
    cmd = BUS_NONE;
    @(negedge clock);
    chk(name, {59'd0, cnt}, {59'd0, exp_cnt});
    @(posedge clock); #1;
  endtask

  // Return monitor
  always @(negedge clock) begin
    if (mon_en) begin
      if (rtag !== 4'd0) begin
        if (q.size() == 0) begin
          chk("unexpected_return", {60'd0, rtag}, 64'd0);
        end else begin
          me = q.pop_front();
          chk("ret_tag", {60'd0, rtag}, {60'd0, me.tag});
          chk("ret_data", rdata, me.data);
          chk("ret_cycle", 64'(cyc), 64'(me.cyc));
        end
      end else begin
        chk("idle_data_zero", rdata, 64'd0);
        if (q.size() != 0 && q[0].cyc <= cyc) begin
          me = q.pop_front();
          chk("missing_return", {60'd0, rtag}, {60'd0, me.tag});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk("reset_tag", {60'd0, rtag}, 64'd0);
    chk("reset_data", rdata, 64'd0);
    chk("reset_count", {59'd0, cnt}, 64'd0);
    chk("reset_resp_none", {60'd0, resp}, 64'd0);
    @(posedge clock); #1;
    mon_en = 1'b1;

    // Store then load the same word
    issue("store_100", BUS_STORE, 32'h100, VA, 4'd1, 64'd0);
    issue("load_100", BUS_LOAD, 32'h100, 64'd0, 4'd1, VA);
    idle(6);

    // Unwritten word, low address bits ignored
    issue("load_108", BUS_LOAD, 32'h108, 64'd0, 4'd1, 64'd0);
    issue("load_10F", BUS_LOAD, 32'h10F, 64'd0, 4'd2, 64'd0);
    idle(6);
    issue("store_10F", BUS_STORE, 32'h10F, VD, 4'd1, 64'd0);
    issue("load_108_b", BUS_LOAD, 32'h108, 64'd0, 4'd1, VD);
    idle(6);

    // Back-to-back loads and outstanding count
    issue("b2b_0", BUS_LOAD, 32'h100, 64'd0, 4'd1, VA);
    issue("b2b_1", BUS_LOAD, 32'h100, 64'd0, 4'd2, VA);
    issue("b2b_2", BUS_LOAD, 32'h108, 64'd0, 4'd3, VD);
    idle_cnt("cnt_c3", 5'd3);
    idle_cnt("cnt_c4", 5'd3);
    idle_cnt("cnt_c5", 5'd2);
    idle_cnt("cnt_c6", 5'd1);
    idle_cnt("cnt_c7", 5'd0);
    idle(2);

    // Load snapshot is unaffected by a later store
    issue("store_A2", BUS_STORE, 32'h200, VA2, 4'd1, 64'd0);
    issue("load_A2", BUS_LOAD, 32'h200, 64'd0, 4'd1, VA2);
    issue("store_B2", BUS_STORE, 32'h200, VB2, 4'd2, 64'd0);
    idle(3);
    issue("load_B2", BUS_LOAD, 32'h200, 64'd0, 4'd1, VB2);
    idle(6);

    // Rejected commands and range boundary
    issue("load_oor", BUS_LOAD, 32'h10000, 64'd0, 4'd0, 64'd0);
    issue("store_oor", BUS_STORE, 32'h10000, 64'hFFFF, 4'd0, 64'd0);
    issue("cmd_3", 2'd3, 32'h100, 64'd0, 4'd0, 64'd0);
    issue("cmd_none", BUS_NONE, 32'h100, 64'd0, 4'd0, 64'd0);
    idle_cnt("cnt_after_reject", 5'd0);
    issue("store_last", BUS_STORE, 32'hFFF8, VC, 4'd1, 64'd0);
    issue("load_last", BUS_LOAD, 32'hFFF8, 64'd0, 4'd1, VC);
    issue("load_word0", BUS_LOAD, 32'h0, 64'd0, 4'd2, 64'd0);
    idle(6);

    // Reset with loads pending
    issue("pre_rst_0", BUS_LOAD, 32'h100, 64'd0, 4'd1, VA);
    issue("pre_rst_1", BUS_LOAD, 32'h100, 64'd0, 4'd2, VA);
    issue("pre_rst_2", BUS_LOAD, 32'h100, 64'd0, 4'd3, VA);
    reset = 1'b1;
    q.delete();
    @(posedge clock); #1;
    reset = 1'b0;
    idle_cnt("cnt_after_reset", 5'd0);
    issue("load_after_reset", BUS_LOAD, 32'h100, 64'd0, 4'd1, 64'd0);
    idle(8);

    // Latency-15 instance: fill all tags
    for (int i = 0; i < 15; i++) begin
      cmd15 = BUS_LOAD;
      @(negedge clock);
      chk("fill15_resp", {60'd0, resp15}, 64'(i + 1));
      @(posedge clock); #1;
    end
    @(negedge clock);
    chk("full15_load_resp", {60'd0, resp15}, 64'd0);
    chk("full15_ret_tag", {60'd0, rtag15}, 64'd1);
    chk("full15_ret_data", rdata15, 64'd0);
    chk("full15_count", {59'd0, cnt15}, 64'd15);
    @(posedge clock); #1;
    @(negedge clock);
    chk("retry15_resp", {60'd0, resp15}, 64'd1);
    @(posedge clock); #1;
    cmd15 = BUS_NONE;
    repeat (20) @(posedge clock);
    #1;
    for (int i = 0; i < 15; i++) begin
      cmd15 = BUS_LOAD;
      @(posedge clock); #1;
    end
    cmd15 = BUS_STORE; addr15 = 32'h8; wdata15 = 64'h55;
    @(negedge clock);
    chk("full15_store_resp", {60'd0, resp15}, 64'd1);
    @(posedge clock); #1;
    cmd15 = BUS_NONE;

    // Drain the scoreboard
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clock);
    #1;
    chk("drain_pending", 64'(q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Tagged data-memory responder: the memory-side end of the proc2Dmem/Dmem2proc bus driven by the data cache.
- Accepts one load or store per cycle and returns a nonzero transaction tag combinationally in the same cycle.
- Stores complete at acceptance. Load data is returned on the tag bus exactly MEM_LATENCY cycles later.
- Used as the synthesizable memory back end in cache testbenches and in the full-pipeline simulation top.

Parameters:
- MEM_LATENCY, 4, cycles from load acceptance to data return (legal range 1..15)
- MEM_WORDS, 8192, number of 64-bit words (byte capacity MEM_WORDS*8)
- NUM_TAGS, 15, outstanding load tags; tag values are 1..NUM_TAGS, 0 means "none"

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- proc2Dmem_command  in  2  BUS_NONE=0, BUS_LOAD=1, BUS_STORE=2; 3 is treated as BUS_NONE
- proc2Dmem_addr  in  XLEN  byte address; bits [2:0] ignored (8-byte aligned)
- proc2Dmem_data  in  64  store data, full 64-bit word
- Dmem2proc_response  out  4  combinational; accepting tag, or 0 = not accepted
- Dmem2proc_data  out  64  registered; load return data, 0 when Dmem2proc_tag==0
- Dmem2proc_tag  out  4  registered; tag whose data is on Dmem2proc_data this cycle, 0 = none
- outstanding_count  out  5  registered; number of busy load tags

Behaviour:
- Reset: all tag entries free; Dmem2proc_tag=0, Dmem2proc_data=0, outstanding_count=0; memory array cleared to 0. Reset mid-operation drops all pending loads with no return.
- Word index = addr[3 +: log2(MEM_WORDS)]. Address is out of range if addr >= MEM_WORDS*8.
- Response (combinational, same cycle as the command):
  - 0 if the command is BUS_NONE/3, the address is out of range, or (for loads) no tag is free.
  - Otherwise, the lowest-numbered free tag.
  - Stores always get a nonzero response while in range: the lowest free tag, or 1 if all tags are busy.
  - A store response is an acknowledge only; no data return is ever issued for a store.
- Store accepted in cycle c: mem[idx] <= proc2Dmem_data at the end of cycle c. A load issued in c+1 sees the new value.
- Load accepted in cycle c with tag T:
  - mem[idx] is snapshotted into entry T at the end of cycle c; later stores do not alter the returned value.
  - T is busy; its countdown is loaded with MEM_LATENCY.
  - Dmem2proc_tag==T and Dmem2proc_data==snapshot during exactly cycle c+MEM_LATENCY, for one cycle.
  - T is not allocatable in cycles c+1..c+MEM_LATENCY, and becomes allocatable from cycle c+MEM_LATENCY+1.
- At most one acceptance per cycle at a fixed latency, so returns never collide. The design still asserts (sim-only) if two entries expire in the same cycle.
- Full: with NUM_TAGS loads outstanding, new loads get response 0 and nothing changes. A load in the same cycle that a tag is returning still sees that tag as busy.
- outstanding_count: +1 on load acceptance, -1 at the end of the return cycle; both may occur in the same cycle (net 0).
- Out-of-range access or a rejected command: no state change.

Decomposition:
- sys_defs package holds:
  - BUS_NONE/BUS_LOAD/BUS_STORE and XLEN
  - MEM_TAG_BITS=4
  - typedef MEM_PEND_ENTRY {busy, countdown[3:0], data[63:0]}
- One sub-module, dmem_tag_table: NUM_TAGS pending entries, lowest-free priority encoder, countdown/expire logic. It outputs the free tag, the expiring tag and its data.
- The top level holds the memory array, range check, response muxing and output registers.

Test Plan (MEM_LATENCY=4, MEM_WORDS=8192):
- Store 0x1111_2222_3333_4444 to 0x100 in cycle 0, load 0x100 in cycle 1 -> store response 1, load response 1 (store holds no tag). Tag 1 and data 0x1111_2222_3333_4444 appear in cycle 5 only; tag is 0 in cycles 2-4 and 6.
- Load 0x108 (never written) -> response 1, data 0 at +4. Load 0x10F -> same word 0x108 (low bits ignored).
- Back-to-back loads in cycles 0,1,2 -> responses 1,2,3; returns tags 1,2,3 in cycles 4,5,6; outstanding_count peaks at 3 and returns to 0 in cycle 7.
- Issue 15 loads in consecutive cycles, with MEM_LATENCY raised to 15 via a parameter override:
  - 16th load in cycle 15 -> response 0 (tag 1 is returning that cycle).
  - Retry in cycle 16 -> response 1.
- Load 0x200 (value A) in cycle 0, store value B to 0x200 in cycle 1 -> return at cycle 4 carries A. A fresh load returns B.
- Address 0x10000 (out of range) -> response 0, no state change. Assert reset in cycle 2 with 3 loads pending -> no returns appear; outstanding_count=0; a load after reset gets response 1.
